// File: rtl/r5p_mdu.sv
// r5p_mdu: iterative RV32M multiply/divide unit, one radix-2 step per cycle
module r5p_mdu #(
  parameter int XW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic [2:0]    req_op,
  input  logic [XW-1:0] rs1,
  input  logic [XW-1:0] rs2,
  input  logic          abort,
  output logic          rsp_vld,
  input  logic          rsp_rdy,
  output logic [XW-1:0] rd
);
  localparam int CW = $clog2(XW);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t          state_q;
  logic [2:0]      op_q;
  logic [XW-1:0]   b_q, lo_q, res_q;
  logic [XW:0]     hi_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q;
  logic            is_div, s1_sg, s2_sg, n1, n2, dz, ov;
  logic [XW-1:0]   m1, m2, spec_res;
  logic [XW:0]     mul_s, div_r, div_t, hi_d;
  logic [XW-1:0]   lo_d, div_sel, div_fin;
  logic [2*XW-1:0] prod, prod_fin;
  logic [XW-1:0]   fin;
  assign req_rdy = (state_q == IDLE);
  assign rsp_vld = (state_q == DONE);
  assign rd      = res_q;
  // request decode: operand magnitudes, result sign and the single-cycle special cases
  always_comb begin
    is_div   = req_op[2];
    s1_sg    = is_div ? !req_op[0] : (req_op[1:0] == 2'd1 || req_op[1:0] == 2'd2);
    s2_sg    = is_div ? !req_op[0] : (req_op[1:0] == 2'd1);
    n1       = s1_sg & rs1[XW-1];
    n2       = s2_sg & rs2[XW-1];
    m1       = n1 ? -rs1 : rs1;
    m2       = n2 ? -rs2 : rs2;
    dz       = is_div && (rs2 == '0);
    ov       = is_div && !req_op[0] && (rs1 == {1'b1, {(XW-1){1'b0}}}) && (rs2 == '1);
    spec_res = dz ? (req_op[1] ? rs1 : '1) : (req_op[1] ? '0 : rs1);
  end
  // one datapath step (shift-add or restoring shift-subtract) plus final sign fix and result select
  always_comb begin
    mul_s    = {1'b0, hi_q[XW-1:0]} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_r    = {hi_q[XW-1:0], lo_q[XW-1]};
    div_t    = div_r - {1'b0, b_q};
    hi_d     = op_q[2] ? (div_t[XW] ? div_r : div_t) : {1'b0, mul_s[XW:1]};
    lo_d     = op_q[2] ? {lo_q[XW-2:0], ~div_t[XW]} : {mul_s[0], lo_q[XW-1:1]};
    prod     = {hi_d[XW-1:0], lo_d};
    prod_fin = neg_q ? -prod : prod;
    div_sel  = op_q[1] ? hi_d[XW-1:0] : lo_d;
    div_fin  = neg_q ? -div_sel : div_sel;
    fin      = op_q[2] ? div_fin : (op_q[1:0] == 2'd0 ? prod_fin[XW-1:0] : prod_fin[2*XW-1:XW]);
  end
  // control FSM and datapath registers; abort overrides everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      b_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else if (abort) begin
      state_q <= IDLE;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_vld) begin
          op_q    <= req_op;
          b_q     <= m2;
          lo_q    <= m1;
          hi_q    <= '0;
          cnt_q   <= CW'(XW-1);
          neg_q   <= (is_div && req_op[1]) ? n1 : (n1 ^ n2);
          res_q   <= spec_res;
          state_q <= (dz || ov) ? DONE : BUSY;
        end
        BUSY: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            res_q   <= fin;
            state_q <= DONE;
          end
        end
        DONE: if (rsp_rdy) begin
          state_q <= IDLE;
          res_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_r5p_mdu.sv
// tb_r5p_mdu: directed-vector bench for the iterative multiply/divide unit
module tb_r5p_mdu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [2:0]  req_op = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        abort = 1'b0;
  logic        rsp_vld;
  logic        rsp_rdy = 1'b0;
  logic [31:0] rd;
  int checks = 0;
  int errors = 0;
  r5p_mdu #(.XW(32)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op),
    .rs1(rs1), .rs2(rs2), .abort(abort), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rd(rd)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op = op; rs1 = a; rs2 = b; req_vld = 1'b1;
    @(posedge clk); #1;
    req_vld = 1'b0; rs1 = $urandom; rs2 = $urandom; req_op = 3'($urandom);
  endtask
  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int lat, input logic [31:0] exp, input int hold);
    int n = 0;
    logic [31:0] held;
    start(op, a, b);
    n = 1;
    while (!rsp_vld && n < 100) begin
      @(posedge clk); #1;
      if (!rsp_vld) n++;
    end
    if (lat == 1) n = rsp_vld ? 1 : n;
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk(tag, rd, exp);
    held = rd;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_rd"}, rd, held);
      chk({tag, "_hold_vld"}, {31'b0, rsp_vld}, 32'd1);
      chk({tag, "_hold_rdy"}, {31'b0, req_rdy}, 32'd0);
    end
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
    chk({tag, "_idle"}, {31'b0, req_rdy}, 32'd1);
    chk({tag, "_rdclr"}, rd, 32'd0);
  endtask
  initial begin
    bit seen;
    #3;
    chk("rst_vld", {31'b0, rsp_vld}, 32'd0);
    chk("rst_rd", rd, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", {31'b0, req_rdy}, 32'd1);
    run("mul",    3'd0, 32'd7, 32'hFFFFFFFD, 32, 32'hFFFFFFEB, 0);
    run("mulh",   3'd1, 32'd7, 32'hFFFFFFFD, 32, 32'hFFFFFFFF, 0);
    run("mulhu",  3'd3, 32'd7, 32'hFFFFFFFD, 32, 32'h00000006, 0);
    run("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'hFFFFFFFF, 0);
    run("mulh2",  3'd1, 32'h80000000, 32'h80000000, 32, 32'h40000000, 0);
    run("div",    3'd4, 32'hFFFFFFEC, 32'd3, 32, 32'hFFFFFFFA, 0);
    run("rem",    3'd6, 32'hFFFFFFEC, 32'd3, 32, 32'hFFFFFFFE, 0);
    run("divu",   3'd5, 32'd20, 32'd3, 32, 32'd6, 0);
    run("remu",   3'd7, 32'd20, 32'd3, 32, 32'd2, 0);
    run("div_ns", 3'd4, 32'd100, 32'hFFFFFFF9, 32, 32'hFFFFFFF2, 0);
    run("rem_ns", 3'd6, 32'd100, 32'hFFFFFFF9, 32, 32'd2, 0);
    run("divu_big", 3'd5, 32'hFFFFFFFF, 32'd1, 32, 32'hFFFFFFFF, 0);
    run("divu_z", 3'd5, 32'h1234, 32'd0, 1, 32'hFFFFFFFF, 0);
    run("rem_z",  3'd6, 32'h1234, 32'd0, 1, 32'h00001234, 0);
    run("div_z",  3'd4, 32'd5, 32'd0, 1, 32'hFFFFFFFF, 0);
    run("div_ov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 0);
    run("rem_ov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 0);
    run("bp",     3'd3, 32'd7, 32'hFFFFFFFD, 32, 32'h00000006, 5);
    start(3'd0, 32'd9, 32'd9);
    repeat (9) @(posedge clk);
    #1;
    chk("abort_busy", {31'b0, req_rdy}, 32'd0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_rdy", {31'b0, req_rdy}, 32'd1);
    chk("abort_vld", {31'b0, rsp_vld}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_vld) seen = 1'b1;
    end
    chk("abort_norsp", {31'b0, seen}, 32'd0);
    start(3'd5, 32'd1000, 32'd7);
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_vld", {31'b0, rsp_vld}, 32'd0);
    chk("arst_rd", rd, 32'd0);
    chk("arst_rdy", {31'b0, req_rdy}, 32'd1);
    @(negedge clk); rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_vld) seen = 1'b1;
    end
    chk("arst_norsp", {31'b0, seen}, 32'd0);
    run("post_mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 32, 32'hFFFFFFFF, 0);
    run("post_mul",    3'd0, 32'hFFFFFFFF, 32'd2, 32, 32'hFFFFFFFE, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
